// File: rtl/user_param_pkg.sv
// Shared types, defaults and step arithmetic for the run-time parameter controller.
package user_param_pkg;

  localparam int PARAM_W    = 12;
  localparam int PARAM_MAX  = 4095;
  localparam int NUM_PARAMS = 3;

  typedef logic [PARAM_W-1:0] param_t;

  typedef enum logic [1:0] {
    PARAM_SOBEL    = 2'd0,
    PARAM_BRIGHT   = 2'd1,
    PARAM_CONTRAST = 2'd2
  } param_idx_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam param_t PARAM_MAX_V      = param_t'(PARAM_MAX);
  localparam param_t SOBEL_DEFAULT    = 12'd1800;
  localparam param_t SOBEL_STEP       = 12'd200;
  localparam param_t BRIGHT_DEFAULT   = 12'd2048;
  localparam param_t BRIGHT_STEP      = 12'd128;
  localparam param_t CONTRAST_DEFAULT = 12'd1024;
  localparam param_t CONTRAST_STEP    = 12'd64;

  function automatic param_t param_step(input param_idx_e idx);
    case (idx)
      PARAM_BRIGHT:   return BRIGHT_STEP;
      PARAM_CONTRAST: return CONTRAST_STEP;
      default:        return SOBEL_STEP;
    endcase
  endfunction

  function automatic param_idx_e next_sel(input param_idx_e idx);
    case (idx)
      PARAM_SOBEL:  return PARAM_BRIGHT;
      PARAM_BRIGHT: return PARAM_CONTRAST;
      default:      return PARAM_SOBEL;
    endcase
  endfunction

  // One extra bit on the sum so an overflow past PARAM_MAX is visible before clamping.
  function automatic param_t step_value(input param_t cur, input param_t step, input logic up);
    logic [PARAM_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (up) begin
      return (sum > {1'b0, PARAM_MAX_V}) ? PARAM_MAX_V : sum[PARAM_W-1:0];
    end
    return (cur < step) ? '0 : cur - step;
  endfunction

endpackage

// File: rtl/user_param_ctrl_if.sv
// Button/frame inputs and committed parameter outputs of user_param_ctrl.
interface user_param_ctrl_if;
  import user_param_pkg::*;

  logic       i_inc;
  logic       i_dec;
  logic       i_sel;
  logic       i_frame_start;
  param_idx_e o_sel;
  param_t     o_sobel_thresh;
  param_t     o_brightness;
  param_t     o_contrast;
  logic       o_pending;
  logic       o_cfg_update;

  modport master (
    output i_inc, i_dec, i_sel, i_frame_start,
    input  o_sel, o_sobel_thresh, o_brightness, o_contrast, o_pending, o_cfg_update
  );

  modport slave (
    input  i_inc, i_dec, i_sel, i_frame_start,
    output o_sel, o_sobel_thresh, o_brightness, o_contrast, o_pending, o_cfg_update
  );
endinterface

// File: rtl/btn_repeat.sv
// Registers a debounced button level, detects its rising edge and emits
// auto-repeat step pulses while the button stays held.
module btn_repeat #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_btn,
  output logic o_step
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic             btn_q;
  logic             btn_qq;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             rep_fire;

  assign rise     = btn_q & ~btn_qq;
  assign rep_fire = btn_q & btn_qq & (cnt == '0);

  // The counter is a countdown to the next repeat; the load values make the
  // first repeat land REPEAT_DELAY cycles after the press pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      btn_q  <= 1'b0;
      btn_qq <= 1'b0;
      cnt    <= '0;
      o_step <= 1'b0;
    end else begin
      btn_q  <= i_btn;
      btn_qq <= btn_q;
      o_step <= rise | rep_fire;
      if (!btn_q) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= DELAY_LOAD;
      end else if (cnt == '0) begin
        cnt <= PERIOD_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_param_ctrl.sv
// Run-time parameter controller: button-driven shadow registers committed to
// the video datapath only at frame boundaries.
module user_param_ctrl
  import user_param_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input logic              i_clk,
  input logic              i_rstn,
  user_param_ctrl_if.slave bus
);

  logic       inc_evt;
  logic       dec_evt;
  logic       sel_q;
  logic       sel_qq;
  logic       sel_evt;
  param_idx_e sel;
  param_t     shadow    [NUM_PARAMS];
  param_t     committed [NUM_PARAMS];
  param_t     step_val;
  logic       step_chg;
  logic       shadow_diff;
  state_e     state;
  state_e     state_nxt;
  logic       commit_en;
  logic       pending_q;
  logic       cfg_update_q;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_btn (bus.i_inc),
    .o_step(inc_evt)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_btn (bus.i_dec),
    .o_step(dec_evt)
  );

  // Select edge pulse is registered so it lines up with the step pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sel_q   <= 1'b0;
      sel_qq  <= 1'b0;
      sel_evt <= 1'b0;
      sel     <= PARAM_SOBEL;
    end else begin
      sel_q   <= bus.i_sel;
      sel_qq  <= sel_q;
      sel_evt <= sel_q & ~sel_qq;
      if (sel_evt) sel <= next_sel(sel);
    end
  end

  // Opposing steps cancel; a saturated step reports no change.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    step_val = shadow[sel];
    step_chg = 1'b0;
    if (inc_evt ^ dec_evt) begin
      step_val = step_value(shadow[sel], param_step(sel), inc_evt);
      step_chg = (step_val != shadow[sel]);
    end
  end

  always_comb begin
    shadow_diff = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (shadow[i] != committed[i]) shadow_diff = 1'b1;
    end
  end

  // NOTE: the parameter arrays are a handful of flops, not RAM, so each entry
  // is explicitly reset to its own default value.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      shadow[PARAM_SOBEL]       <= SOBEL_DEFAULT;
      shadow[PARAM_BRIGHT]      <= BRIGHT_DEFAULT;
      shadow[PARAM_CONTRAST]    <= CONTRAST_DEFAULT;
      committed[PARAM_SOBEL]    <= SOBEL_DEFAULT;
      committed[PARAM_BRIGHT]   <= BRIGHT_DEFAULT;
      committed[PARAM_CONTRAST] <= CONTRAST_DEFAULT;
    end else begin
      if (step_chg) shadow[sel] <= step_val;
      if (commit_en) committed <= shadow;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      pending_q    <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending_q    <= (state_nxt != IDLE);
      cfg_update_q <= commit_en;
    end
  end

  // A step landing in the commit cycle is not part of this frame's copy, so
  // it re-arms for the next frame.
  always_comb begin
    state_nxt = state;
    commit_en = 1'b0;
    case (state)
      IDLE:    if (shadow_diff) state_nxt = ARMED;
      ARMED:   if (bus.i_frame_start) state_nxt = COMMIT;
      COMMIT: begin
        commit_en = 1'b1;
        state_nxt = step_chg ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_sel          = sel;
  assign bus.o_sobel_thresh = committed[PARAM_SOBEL];
  assign bus.o_brightness   = committed[PARAM_BRIGHT];
  assign bus.o_contrast     = committed[PARAM_CONTRAST];
  assign bus.o_pending      = pending_q;
  assign bus.o_cfg_update   = cfg_update_q;

endmodule

// File: tb/tb_user_param_ctrl.sv
// Self-checking bench for user_param_ctrl: directed button/frame stimulus with a
// cycle-level behavioural model compared against the outputs every cycle.
module tb_user_param_ctrl;
  import user_param_pkg::*;

  localparam int DELAY  = 20;
  localparam int PERIOD = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  user_param_ctrl_if bus ();

  user_param_ctrl #(.REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cfg_count = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int DEF [3] = '{1800, 2048, 1024};
  localparam int STP [3] = '{200, 128, 64};

  int m_sh [3] = '{1800, 2048, 1024};
  int m_cm [3] = '{1800, 2048, 1024};
  int m_sel = 0;
  bit m_pend = 0, m_commit_now = 0, m_cfg = 0;
  int h_inc [2] = '{0, 0};
  int h_dec [2] = '{0, 0};
  bit s_sel [3] = '{0, 0, 0};

  // A held button steps once on the press, then at DELAY, DELAY+PERIOD, ...
  // cycles of continuous holding.
  function automatic bit step_due(input int held);
    return (held == 1) || ((held - 1 >= DELAY) && ((held - 1 - DELAY) % PERIOD == 0));
  endfunction

  task automatic model_reset();
    m_sh = DEF; m_cm = DEF; m_sel = 0;
    m_pend = 0; m_commit_now = 0; m_cfg = 0;
    h_inc = '{0, 0}; h_dec = '{0, 0}; s_sel = '{0, 0, 0};
  endtask

  task automatic model_step();
    bit iev, dev, sev, changed, diff;
    int old_sh [3];
    int nv;
    // Events visible now come from inputs sampled two edges earlier.
    iev = step_due(h_inc[1]);
    dev = step_due(h_dec[1]);
    sev = s_sel[1] && !s_sel[2];
    h_inc[1] = h_inc[0]; h_inc[0] = bus.i_inc ? h_inc[0] + 1 : 0;
    h_dec[1] = h_dec[0]; h_dec[0] = bus.i_dec ? h_dec[0] + 1 : 0;
    s_sel[2] = s_sel[1]; s_sel[1] = s_sel[0]; s_sel[0] = bus.i_sel;

    old_sh = m_sh;
    diff = 0;
    for (int i = 0; i < 3; i++) if (m_sh[i] != m_cm[i]) diff = 1;
    m_cfg = m_commit_now;
    if (m_commit_now) m_cm = old_sh;

    changed = 0;
    if (iev != dev) begin
      nv = iev ? m_sh[m_sel] + STP[m_sel] : m_sh[m_sel] - STP[m_sel];
      if (nv > 4095) nv = 4095;
      if (nv < 0) nv = 0;
      changed = (nv != m_sh[m_sel]);
      m_sh[m_sel] = nv;
    end
    if (sev) m_sel = (m_sel + 1) % 3;

    if (m_commit_now) begin
      m_pend = changed;
      m_commit_now = 0;
    end else if (m_pend) begin
      m_commit_now = bus.i_frame_start;
    end else begin
      m_pend = diff;
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_sobel",      int'(bus.o_sobel_thresh), m_cm[0]);
      check("cmp_brightness", int'(bus.o_brightness),   m_cm[1]);
      check("cmp_contrast",   int'(bus.o_contrast),     m_cm[2]);
      check("cmp_sel",        int'(bus.o_sel),          m_sel);
      check("cmp_pending",    int'(bus.o_pending),      int'(m_pend));
      check("cmp_cfg_update", int'(bus.o_cfg_update),   int'(m_cfg));
      if (bus.o_cfg_update) cfg_count++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0:       bus.i_inc = v;
      1:       bus.i_dec = v;
      default: bus.i_sel = v;
    endcase
  endtask

  task automatic press(input int which, input int n);
    repeat (n) begin
      drive(which, 1'b1); tick(2);
      drive(which, 1'b0); tick(2);
    end
  endtask

  task automatic frame();
    bus.i_frame_start = 1'b1; tick(1);
    bus.i_frame_start = 1'b0;
  endtask

  int c0;

  initial begin
    bus.i_inc = 1'b0; bus.i_dec = 1'b0; bus.i_sel = 1'b0; bus.i_frame_start = 1'b0;
    @(posedge clk);
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(1);

    // Reset values
    check("rst_sobel",      int'(bus.o_sobel_thresh), 1800);
    check("rst_brightness", int'(bus.o_brightness),   2048);
    check("rst_contrast",   int'(bus.o_contrast),     1024);
    check("rst_sel",        int'(bus.o_sel),          0);
    check("rst_pending",    int'(bus.o_pending),      0);

    // Sobel decremented to zero, committed on a frame
    press(1, 9); tick(4);
    check("dec_pending",      int'(bus.o_pending),      1);
    check("dec_uncommitted",  int'(bus.o_sobel_thresh), 1800);
    check("model_sobel_sh",   m_sh[0],                  0);
    c0 = cfg_count;
    frame(); tick(4);
    check("dec_committed",    int'(bus.o_sobel_thresh), 0);
    check("dec_cfg_pulses",   cfg_count - c0,           1);
    press(1, 1); tick(4);
    check("dec_sat_pending",  int'(bus.o_pending),      0);

    // Contrast saturates high
    press(2, 2); tick(3);
    check("sel_contrast",     int'(bus.o_sel),          2);
    press(0, 60); tick(4);
    frame(); tick(4);
    check("contrast_max",     int'(bus.o_contrast),     4095);
    check("model_contrast",   m_cm[2],                  4095);
    press(0, 1); tick(4);
    check("inc_sat_pending",  int'(bus.o_pending),      0);

    // Auto-repeat on brightness
    press(2, 1); tick(3);
    check("sel_wrap",         int'(bus.o_sel),          0);
    press(2, 1); tick(3);
    check("sel_bright",       int'(bus.o_sel),          1);
    bus.i_inc = 1'b1; tick(40);
    bus.i_inc = 1'b0; tick(6);
    check("rep_uncommitted",  int'(bus.o_brightness),   2048);
    check("rep_pending",      int'(bus.o_pending),      1);
    check("model_bright_sh",  m_sh[1],                  2688);
    frame(); tick(4);
    check("rep_committed",    int'(bus.o_brightness),   2688);

    // Simultaneous inc+dec cancel; sel+inc steps the old selection
    bus.i_inc = 1'b1; bus.i_dec = 1'b1; tick(2);
    bus.i_inc = 1'b0; bus.i_dec = 1'b0; tick(6);
    check("cancel_pending",   int'(bus.o_pending),      0);
    bus.i_inc = 1'b1; bus.i_sel = 1'b1; tick(2);
    bus.i_inc = 1'b0; bus.i_sel = 1'b0; tick(6);
    check("selinc_sel",       int'(bus.o_sel),          2);
    check("selinc_pending",   int'(bus.o_pending),      1);
    frame(); tick(4);
    check("selinc_bright",    int'(bus.o_brightness),   2816);
    check("selinc_contrast",  int'(bus.o_contrast),     4095);
    press(2, 1); tick(3);
    check("sel_to_sobel",     int'(bus.o_sel),          0);
    press(2, 3); tick(3);
    check("sel_three_wrap",   int'(bus.o_sel),          0);

    // Frame gating: frame at 5 is ignored (idle), frame at 30 commits the step at 10
    for (int c = 0; c < 36; c++) begin
      bus.i_frame_start = (c == 5 || c == 30);
      bus.i_inc         = (c == 10 || c == 11);
      if (c == 7)  check("gate_early_sobel", int'(bus.o_sobel_thresh), 0);
      if (c == 29) check("gate_before",      int'(bus.o_sobel_thresh), 0);
      if (c == 29) check("gate_armed",       int'(bus.o_pending),      1);
      if (c == 33) check("gate_after",       int'(bus.o_sobel_thresh), 200);
      tick(1);
    end

    // Step landing in the commit cycle re-arms for the next frame
    press(0, 1); tick(3);
    c0 = cfg_count;
    bus.i_inc = 1'b1; tick(1);
    bus.i_frame_start = 1'b1; tick(1);
    bus.i_frame_start = 1'b0; tick(1);
    bus.i_inc = 1'b0; tick(6);
    check("commit_step_sobel",   int'(bus.o_sobel_thresh), 400);
    check("commit_step_pending", int'(bus.o_pending),      1);
    check("commit_step_pulses",  cfg_count - c0,           1);
    frame(); tick(4);
    check("commit_step_next",    int'(bus.o_sobel_thresh), 600);

    // Asynchronous reset while armed
    press(0, 1); tick(3);
    check("armed_before_rst", int'(bus.o_pending), 1);
    c0 = cfg_count;
    #2 rstn = 1'b0;
    #1;
    check("arst_sobel",      int'(bus.o_sobel_thresh), 1800);
    check("arst_brightness", int'(bus.o_brightness),   2048);
    check("arst_contrast",   int'(bus.o_contrast),     1024);
    check("arst_sel",        int'(bus.o_sel),          0);
    check("arst_pending",    int'(bus.o_pending),      0);
    check("arst_cfg",        int'(bus.o_cfg_update),   0);
    tick(2);
    rstn = 1'b1;
    tick(4);
    check("arst_no_pulse",   cfg_count - c0,           0);
    check("arst_idle",       int'(bus.o_pending),      0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_param_ctrl.md
# user_param_ctrl

Run-time parameter controller for the video-processing datapath. It takes debounced button levels (increment, decrement, select) and maintains three 12-bit processing parameters in shadow registers: Sobel threshold, brightness offset and contrast gain. Holding a button auto-repeats the step. Changes are committed to the datapath only at a frame boundary, so a frame is never processed with mixed settings. It sits between the button debouncers and the Sobel / pixel-adjust stages.

## Interface
- `REPEAT_DELAY`, default 50_000_000: cycles a button must be held before auto-repeat starts (0.5 s at 100 MHz).
- `REPEAT_PERIOD`, default 10_000_000: cycles between auto-repeat steps.
- `i_clk` in 1: system clock, 100 MHz.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_inc` in 1: debounced increment button level.
- `i_dec` in 1: debounced decrement button level.
- `i_sel` in 1: debounced select button level; each press advances to the next parameter.
- `i_frame_start` in 1: single-cycle pulse at the start of each frame (vsync).
- `o_sel` out 2: current selection (0 = Sobel, 1 = brightness, 2 = contrast).
- `o_sobel_thresh` out 12: committed Sobel threshold.
- `o_brightness` out 12: committed brightness offset.
- `o_contrast` out 12: committed contrast gain.
- `o_pending` out 1: shadow differs from committed; a commit is waiting for the next frame.
- `o_cfg_update` out 1: single-cycle pulse in the cycle the committed outputs change.

## Operation
- Reset (async assert) sets each shadow and committed parameter to its default:
  - Sobel: default 1800, step 200.
  - Brightness: default 2048, step 128.
  - Contrast: default 1024, step 64.
  - Max for all three is 4095.
- Reset also sets `o_sel`=0, `o_pending`=0 and `o_cfg_update`=0, clears the repeat counters and sets the FSM to IDLE.
- Each button input is registered once, then rising-edge detected. A rising edge produces one step event.
- Auto-repeat:
  - While `i_inc` or `i_dec` stays high, a counter runs.
  - The first repeat event fires `REPEAT_DELAY` cycles after the rising edge.
  - Further repeat events fire every `REPEAT_PERIOD` cycles after that.
  - Releasing the button clears the counter.
  - `i_sel` never repeats.
- Step arithmetic uses 13-bit intermediates:
  - Increment: new = min(cur + step, 4095).
  - Decrement: new = (cur < step) ? 0 : cur − step.
  - Only the selected shadow register changes.
- Simultaneous events:
  - Inc and dec events in the same cycle cancel: no change, no pending.
  - A sel event together with a step event: the step applies to the old selection, and `o_sel` advances in the same cycle.
- Selection wraps 2 → 0. The value 3 is never produced.
- A step that leaves the value unchanged (already saturated) does not set pending.
- FSM:
  - IDLE → ARMED when any shadow ≠ committed.
  - ARMED → COMMIT on `i_frame_start`.
  - COMMIT lasts one cycle: copy all shadows to committed, pulse `o_cfg_update`, then go to IDLE. If a step event arrives in the COMMIT cycle, go to ARMED instead.
  - Step events in ARMED or COMMIT update the shadow registers normally.
  - `i_frame_start` while in IDLE is ignored.
- `o_pending` = (state ≠ IDLE), i.e. high in ARMED and COMMIT.

## Timing
- A button rising edge at input cycle N updates the shadow at the edge N+2 (1 register stage plus 1 edge-detect stage). `o_pending` is high from N+3.
- An `i_frame_start` sampled in ARMED at edge F produces committed outputs and `o_cfg_update` valid after edge F+1.
- Worst-case latency from button press to datapath is 1 frame plus 3 cycles.
- Reset mid-commit: the async reset overrides everything. Outputs return to defaults immediately, with no `o_cfg_update` pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- The package `user_param_pkg` holds:
  - A parameter index enum with `PARAM_SOBEL`, `PARAM_BRIGHT` and `PARAM_CONTRAST`.
  - Per-parameter DEFAULT and STEP constants, plus `PARAM_MAX` = 4095 and `PARAM_W` = 12.
  - A state enum with IDLE, ARMED and COMMIT.
- One sub-module, `btn_repeat`, is instantiated twice (inc and dec). It does registering, edge detection and the auto-repeat counter, and outputs a single-cycle step pulse.
- Selection edge detection stays inline in the top module.

## Test plan
Benches override `REPEAT_DELAY`=20 and `REPEAT_PERIOD`=5.
- **Reset and commit:** after reset, outputs are 1800/2048/1024 and `o_sel`=0. Press dec 9 times, then pulse `i_frame_start` → `o_sobel_thresh` goes 1800 → 0 in one step, saturates at 0, and `o_cfg_update` pulses once.
- **Saturation high:** select contrast (2 sel presses), press inc 60 times, pulse frame → `o_contrast`=4095. One further inc does not raise `o_pending`.
- **Auto-repeat:** hold `i_inc` for 40 cycles on brightness → 1 + 4 steps, so the shadow is 2048 + 5·128 = 2688. The committed value stays 2048 until `i_frame_start`.
- **Simultaneous events:** inc and dec rising edges in the same cycle → no change and `o_pending` stays 0. Sel with inc → the old parameter is stepped and `o_sel` advances. Sel pressed 3 times wraps to 0.
- **Frame gating:** step at cycle 10, frame pulses at cycles 5 and 30 → outputs unchanged at cycle 5 and updated after cycle 31. A step arriving during COMMIT leaves `o_pending` high for the next frame.
- **Reset mid-operation:** deassert `i_rstn` while in ARMED → all outputs return to defaults asynchronously and no `o_cfg_update` pulse occurs.
